// File: rtl/ps2_colour_sequencer_if.sv
// Byte-in / colour-out bundle between the PS/2 receiver, the command sequencer and the VGA path.
// master = byte source (receiver side), slave = sequencer.
interface ps2_colour_sequencer_if;
  logic [7:0]  scanCode;
  logic        scanValid;
  logic [11:0] regionColour;
  logic        armed;
  logic        cmdValid;
  logic [1:0]  cmdRegion;
  logic [2:0]  cmdColour;
  logic        seqError;

  modport master (
    output scanCode, scanValid,
    input  regionColour, armed, cmdValid, cmdRegion, cmdColour, seqError
  );

  modport slave (
    input  scanCode, scanValid,
    output regionColour, armed, cmdValid, cmdRegion, cmdColour, seqError
  );
endinterface

// File: rtl/ps2_colour_sequencer.sv
// Scancode filter plus "region then colour" command FSM toggling RGB bits of four region colours.
// Optional ARMED timeout enabled by defining PS2_SEQ_TIMEOUT_EN.
//
//  state  | meaning
//  IDLE   | waiting for a region key; a colour key here is a sequence error
//  ARMED  | region latched, waiting for a colour key (optionally with timeout)
//  COMMIT | one cycle with the toggled colour on the outputs; keys use IDLE rules
module ps2_colour_sequencer #(
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input logic clk,
  input logic reset,
  ps2_colour_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, COMMIT} state_t;

  state_t      state, next_state;
  logic        brk_pend, ext_pend;
  logic        raw_region, raw_colour;
  logic [1:0]  raw_reg;
  logic [2:0]  raw_mask;
  logic        dec_region, dec_colour;
  logic [1:0]  dec_reg;
  logic [2:0]  dec_mask;
  logic [1:0]  region_q;
  logic [2:0]  colour_q [4];
  logic        do_commit, err_next, timeout_hit;

  always_comb begin
    raw_region = 1'b0;
    raw_colour = 1'b0;
    raw_reg    = 2'd0;
    raw_mask   = 3'b000;
    case (bus.scanCode)
      8'h16: begin raw_region = 1'b1; raw_reg = 2'd0; end
      8'h1E: begin raw_region = 1'b1; raw_reg = 2'd1; end
      8'h26: begin raw_region = 1'b1; raw_reg = 2'd2; end
      8'h25: begin raw_region = 1'b1; raw_reg = 2'd3; end
      8'h2D: begin raw_colour = 1'b1; raw_mask = 3'b100; end
      8'h34: begin raw_colour = 1'b1; raw_mask = 3'b010; end
      8'h32: begin raw_colour = 1'b1; raw_mask = 3'b001; end
      default: ;
    endcase
  end

  // Prefix filter and registered decode: the FSM only ever sees clean make codes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brk_pend   <= 1'b0;
      ext_pend   <= 1'b0;
      dec_region <= 1'b0;
      dec_colour <= 1'b0;
      dec_reg    <= 2'd0;
      dec_mask   <= 3'b000;
    end else begin
      dec_region <= 1'b0;
      dec_colour <= 1'b0;
      if (bus.scanValid) begin
        if (bus.scanCode == 8'hF0) begin
          brk_pend <= 1'b1;
        end else if (bus.scanCode == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (brk_pend || ext_pend) begin
          brk_pend <= 1'b0;
          ext_pend <= 1'b0;
        end else begin
          dec_region <= raw_region;
          dec_colour <= raw_colour;
          dec_reg    <= raw_reg;
          dec_mask   <= raw_mask;
        end
      end
    end
  end

`ifdef PS2_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] timer;

  assign timeout_hit = (timer == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (state == ARMED && !dec_region && !timeout_hit) begin
      timer <= timer + 1'b1;
    end else begin
      timer <= '0;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC >= 2);
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    do_commit  = 1'b0;
    err_next   = 1'b0;
    case (state)
      ARMED: begin
        if (dec_colour) begin
          next_state = COMMIT;
          do_commit  = 1'b1;
        end else if (!dec_region && timeout_hit) begin
          next_state = IDLE;
          err_next   = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
        if (dec_region)      next_state = ARMED;
        else if (dec_colour) err_next   = 1'b1;
      end
    endcase
  end

  // Outputs are registered on the edge that enters COMMIT so they are valid during it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      region_q      <= 2'd0;
      colour_q      <= '{default: 3'b000};
      bus.armed     <= 1'b0;
      bus.cmdValid  <= 1'b0;
      bus.cmdRegion <= 2'd0;
      bus.cmdColour <= 3'b000;
      bus.seqError  <= 1'b0;
    end else begin
      bus.armed    <= (next_state == ARMED);
      bus.cmdValid <= do_commit;
      bus.seqError <= err_next;
      if (dec_region) region_q <= dec_reg;
      if (do_commit) begin
        colour_q[region_q] <= colour_q[region_q] ^ dec_mask;
        bus.cmdRegion      <= region_q;
        bus.cmdColour      <= colour_q[region_q] ^ dec_mask;
      end
    end
  end

  assign bus.regionColour = {colour_q[3], colour_q[2], colour_q[1], colour_q[0]};

endmodule
